adc_scaler_pipe: RTL
====================

# adc_scaler_pipe

Parametrised, valid-qualified successor to the team's fixed 14-bit ADC scaling stage. Takes signed ADC samples, optionally inverts them, clamps them to a programmable window with clip flags, and scales by a rational gain `GAIN_NUM / 2^GAIN_SHIFT` into an unsigned DAC/display code. It also keeps saturating clip-event counters. A compile-time boxcar averager can be added. Sits between the ADC capture register and the DAC/readout path.

## Interface
Parameters:
- `IN_W`, 14: signed input sample width.
- `OUT_W`, 12: unsigned output code width.
- `INVERT`, 1: 1 = negate the sample before clamping; 0 = pass it through.
- `LO_LIM`, 0: lower clamp bound (signed, IN_W+1 bits).
- `HI_LIM`, 3185: upper clamp bound; must satisfy LO_LIM ≤ HI_LIM.
- `GAIN_NUM`, 5: unsigned gain numerator.
- `GAIN_SHIFT`, 2: gain denominator exponent.
- `CNT_W`, 16: width of the clip counters.
- `AVG_LOG2`, 2: log2 of the averaging window; used only with `ADC_SCALER_AVG_EN`.

Ports:
- `clk`, in, 1: the single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `adc_dat` is valid this cycle.
- `adc_dat`, in, IN_W: signed sample.
- `clr_cnt`, in, 1: synchronous clear of both clip counters.
- `out_valid`, out, 1: `out` and `trunc` are valid this cycle (single-cycle pulse).
- `out`, out, OUT_W: scaled unsigned code.
- `trunc`, out, 2: 01 = clipped low, 10 = clipped high, 00 = in range.
- `lo_cnt`, out, CNT_W: count of low clips.
- `hi_cnt`, out, CNT_W: count of high clips.

## Operation
- There is no backpressure. The pipeline advances every cycle, and valid bubbles propagate alongside the data.
- Stage 1 (bias): `b = INVERT ? -adc_dat : adc_dat`, computed at IN_W+1 bits so that −2^(IN_W−1) negates without overflow.
- Stage 2 (clamp):
  - b < LO_LIM → c = LO_LIM, flag 01.
  - b > HI_LIM → c = HI_LIM, flag 10.
  - Otherwise c = b, flag 00.
  - Clip counters update here, and only on valid samples.
- Stage 3 (gain):
  - `s = (c − LO_LIM) * GAIN_NUM >> GAIN_SHIFT`, a logical shift that truncates toward zero.
  - The product width is IN_W+1+clog2(GAIN_NUM+1).
  - If s > 2^OUT_W−1, the result is saturated to 2^OUT_W−1. The trunc flag is not altered by this saturation.
- Counters:
  - Each counter increments by 1 per matching valid clip and saturates at 2^CNT_W−1 (no wrap).
  - `clr_cnt` wins over a simultaneous increment: the counter goes to 0 that cycle.
- `trunc` is always aligned with the `out` sample it describes.

## Timing
- Reset values: `out`=0, `trunc`=00, `out_valid`=0, `lo_cnt`=`hi_cnt`=0. All pipeline valid bits and the averager state are also cleared.
- Reset is asynchronous assert and synchronous deassert. Samples in flight when reset asserts are discarded and never emerge.
- Latency without averaging: `in_valid` at cycle N → `out_valid` at N+3.
- Counter latency: `lo_cnt`/`hi_cnt` reflect a sample at N+2.
- Throughput is one sample per cycle. Back-to-back valids produce back-to-back outputs.

## Configuration
- Macro: `ADC_SCALER_AVG_EN`.
- Defined:
  - Stage 3 results feed an accumulator of width OUT_W+AVG_LOG2.
  - After 2^AVG_LOG2 valid samples, `out` = sum >> AVG_LOG2 and `out_valid` pulses one cycle after the window's last stage-3 result, i.e. N+4 for the last input.
  - `trunc` is the bitwise OR of the flags over the window.
  - The accumulator clears on each dump. The window counter clears only on reset.
  - Invalid cycles do not advance the window.
  - The clip counters still count individual samples.
- Undefined: no averager logic is present; one output per input at N+3.

## Test plan
- Defaults, in-range value: `adc_dat`=−100 → 3 cycles later `out`=125, `trunc`=00, `out_valid`=1 for one cycle.
- Low clip: `adc_dat`=+50 (b=−50) → `out`=0, `trunc`=01, `lo_cnt` 0→1. Then `adc_dat`=−8192 → `out`=3981, `trunc`=10, `hi_cnt`=1.
- Stream and bubbles: `in_valid` pattern 1,0,1,1 with `adc_dat` −4,x,−8,−12 → `out_valid` pattern 1,0,1,1 at N+3, with `out` = 5,10,15.
- Counter edges:
  - With CNT_W=2: 5 consecutive high clips → `hi_cnt` holds 3.
  - A high clip in the same cycle as `clr_cnt` → `hi_cnt`=0 next cycle.
- Reset mid-stream: assert `rst_n`=0 with 2 samples in flight → all outputs 0 immediately, and no `out_valid` after release until new input arrives.
- With `ADC_SCALER_AVG_EN`, AVG_LOG2=2: inputs −100, −200, −300, −400 plus one high clip in a second window → first window gives `out`=312, `trunc`=00, one pulse only. The second window reports `trunc`=10.

Source files
------------

// File: rtl/adc_scaler_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_scaler_pipe                                               |
// | Purpose  : Signed ADC sample -> optional invert -> window clamp with     |
// |            clip flags/counters -> rational gain -> saturated unsigned    |
// |            code. Optional boxcar averager enabled by ADC_SCALER_AVG_EN.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adc_scaler_pipe #(
   parameter int                 IN_W       = 14,
   parameter int                 OUT_W      = 12,
   parameter bit                 INVERT     = 1'b1,
   parameter logic signed [IN_W:0] LO_LIM   = 0,
   parameter logic signed [IN_W:0] HI_LIM   = 3185,
   parameter int unsigned        GAIN_NUM   = 5,
   parameter int unsigned        GAIN_SHIFT = 2,
   parameter int                 CNT_W      = 16,
   parameter int                 AVG_LOG2   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic signed [IN_W-1:0] adc_dat,
   input  logic                   clr_cnt,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out,
   output logic [1:0]             trunc,
   output logic [CNT_W-1:0]       lo_cnt,
   output logic [CNT_W-1:0]       hi_cnt
);

   localparam int c_PROD_W = IN_W + 1 + $clog2(GAIN_NUM + 1);
   localparam int c_EXT_W  = (c_PROD_W > OUT_W) ? c_PROD_W : OUT_W;
   localparam logic [OUT_W-1:0] c_OUT_MAX = '1;

   // Stage 1: sign-extend one bit so the most negative sample negates cleanly
   logic signed [IN_W:0] w_ext;
   logic signed [IN_W:0] w_b;
   logic signed [IN_W:0] r_b;
   logic                 r_v1;

   assign w_ext = {adc_dat[IN_W-1], adc_dat};
   assign w_b   = INVERT ? -w_ext : w_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b  <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_b  <= w_b;
         r_v1 <= in_valid;
      end
   end

   // Stage 2: clamp and clip flags
   logic                 w_lo;
   logic                 w_hi;
   logic signed [IN_W:0] r_c;
   logic [1:0]           r_tr2;
   logic                 r_v2;
   logic [CNT_W-1:0]     r_lo_cnt;
   logic [CNT_W-1:0]     r_hi_cnt;

   assign w_lo = (r_b < LO_LIM);
   assign w_hi = (r_b > HI_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c   <= '0;
         r_tr2 <= 2'b00;
         r_v2  <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (w_lo) begin
            r_c   <= LO_LIM;
            r_tr2 <= 2'b01;
         end else if (w_hi) begin
            r_c   <= HI_LIM;
            r_tr2 <= 2'b10;
         end else begin
            r_c   <= r_b;
            r_tr2 <= 2'b00;
         end
      end
   end

   // Clip counters saturate; clear takes priority over a same-cycle clip
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo_cnt <= '0;
         r_hi_cnt <= '0;
      end else if (clr_cnt) begin
         r_lo_cnt <= '0;
         r_hi_cnt <= '0;
      end else begin
         if (r_v1 && w_lo && (r_lo_cnt != '1))
            r_lo_cnt <= r_lo_cnt + 1'b1;
         if (r_v1 && w_hi && (r_hi_cnt != '1))
            r_hi_cnt <= r_hi_cnt + 1'b1;
      end
   end

   assign lo_cnt = r_lo_cnt;
   assign hi_cnt = r_hi_cnt;

   // Stage 3: offset is never negative after clamping, so modulo subtraction is exact
   logic [IN_W:0]       w_mag;
   logic [c_PROD_W-1:0] w_prod;
   logic [c_PROD_W-1:0] w_sh;
   logic [c_EXT_W-1:0]  w_sh_ext;
   logic [OUT_W-1:0]    w_s;
   logic [OUT_W-1:0]    r_g_out;
   logic [1:0]          r_g_tr;
   logic                r_g_val;

   assign w_mag    = r_c - LO_LIM;
   assign w_prod   = c_PROD_W'(w_mag) * c_PROD_W'(GAIN_NUM);
   assign w_sh     = w_prod >> GAIN_SHIFT;
   assign w_sh_ext = c_EXT_W'(w_sh);
   assign w_s      = (w_sh_ext > c_EXT_W'(c_OUT_MAX)) ? c_OUT_MAX : w_sh_ext[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_g_out <= '0;
         r_g_tr  <= 2'b00;
         r_g_val <= 1'b0;
      end else begin
         r_g_out <= w_s;
         r_g_tr  <= r_tr2;
         r_g_val <= r_v2;
      end
   end

`ifdef ADC_SCALER_AVG_EN
   localparam int c_ACC_W = OUT_W + AVG_LOG2;

   logic [c_ACC_W-1:0]  r_acc;
   logic [c_ACC_W-1:0]  w_sum;
   logic [AVG_LOG2-1:0] r_win;
   logic [1:0]          r_tor;
   logic [OUT_W-1:0]    r_a_out;
   logic [1:0]          r_a_tr;
   logic                r_a_val;

   assign w_sum = r_acc + c_ACC_W'(r_g_out);

   // Window position survives dumps; only reset returns it to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_win   <= '0;
         r_tor   <= 2'b00;
         r_a_out <= '0;
         r_a_tr  <= 2'b00;
         r_a_val <= 1'b0;
      end else begin
         r_a_val <= 1'b0;
         if (r_g_val) begin
            r_win <= r_win + 1'b1;
            if (r_win == '1) begin
               r_a_out <= w_sum[c_ACC_W-1:AVG_LOG2];
               r_a_tr  <= r_tor | r_g_tr;
               r_a_val <= 1'b1;
               r_acc   <= '0;
               r_tor   <= 2'b00;
            end else begin
               r_acc <= w_sum;
               r_tor <= r_tor | r_g_tr;
            end
         end
      end
   end

   assign out       = r_a_out;
   assign trunc     = r_a_tr;
   assign out_valid = r_a_val;
`else
   assign out       = r_g_out;
   assign trunc     = r_g_tr;
   assign out_valid = r_g_val;
`endif

endmodule
`default_nettype wire
